// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - handshake bundle between a BCD producer, the converter and the binary consumer
// Input side: in_valid/in_ready/bcd_in. Output side: out_valid/out_ready/bin_out/err.

interface bcd_to_bin_seq_if #(
    parameter int NUM_DIGITS = 5,
    parameter int BIN_W      = 17
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_W-1:0]        bin_out;
    logic                    err;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter using reverse double-dabble, one bit per clock
// Optional invalid-digit detection is built when the macro BCD_CHECK_EN is defined.

module bcd_to_bin_seq #(
    parameter int NUM_DIGITS = 5,
    parameter int BIN_W      = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_to_bin_seq_if.slave  bus
);
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIG_W-1:0]   r_dig;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin_out;
    logic               r_out_valid;
    logic [DIG_W-1:0]   w_dig_sh;
    logic [DIG_W-1:0]   w_dig_fix;
    logic [BIN_W-1:0]   w_bin_sh;
    logic               w_accept;
    logic               w_last;
    logic               w_bad;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_state == S_CONV) && (r_cnt == CNT_W'(1));

    // Digit register and binary register form one shift chain; the digit LSB falls into the binary MSB.
    assign {w_dig_sh, w_bin_sh} = {r_dig, r_bin} >> 1;

    always_comb begin
        w_dig_fix = w_dig_sh;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_dig_sh[4*k+3]) begin
                w_dig_fix[4*k +: 4] = w_dig_sh[4*k +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic r_err;

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bus.bcd_in[4*k +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign w_bad   = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = w_bad ? S_ERR : S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_ERR:  w_next = S_DONE;
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig       <= '0;
            r_bin       <= '0;
            r_cnt       <= '0;
            r_bin_out   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dig <= bus.bcd_in;
                r_bin <= '0;
                r_cnt <= CNT_W'(BIN_W);
            end else if (r_state == S_CONV) begin
                r_dig <= w_dig_fix;
                r_bin <= w_bin_sh;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_bin_out   <= w_bin_sh;
                    r_out_valid <= 1'b1;
                end
            end else if (r_state == S_ERR) begin
                r_bin_out   <= '0;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_DONE) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef BCD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_ERR) begin
            r_err <= 1'b1;
        end else if (w_last) begin
            r_err <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin_out;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - scoreboard bench for bcd_to_bin_seq with a decimal-arithmetic reference model
// Honours BCD_CHECK_EN the same way the design does.

module tb_bcd_to_bin_seq;
    localparam int ND = 5;
    localparam int BW = 17;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus();

    bcd_to_bin_seq #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint bin;
        bit     err;
        bit     chk_bin;
        longint lat;
        longint acc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   got;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    bit     rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [4*ND-1:0] b, input longint acc);
        exp_t   e;
        longint v = 0;
        bit     bad = 1'b0;
        for (int k = ND - 1; k >= 0; k--) begin
            int d = int'(b[4*k +: 4]);
            if (d > 9) bad = 1'b1;
            v = v * 10 + d;
        end
        e.acc = acc;
`ifdef BCD_CHECK_EN
        e.bin     = bad ? 0 : v;
        e.err     = bad;
        e.chk_bin = 1'b1;
        e.lat     = bad ? 1 : BW;
`else
        e.bin     = v;
        e.err     = 1'b0;
        e.chk_bin = !bad;
        e.lat     = BW;
`endif
        return e;
    endfunction

    logic           prev_v = 1'b0;
    logic           prev_rdy = 1'b0;
    logic [BW-1:0]  prev_bin = '0;
    logic           prev_err = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                check("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            end
            if (bus.out_valid && prev_v && !prev_rdy) begin
                check("hold_bin", bus.bin_out, prev_bin);
                check("hold_err", bus.err, prev_err);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                if (got.chk_bin) check("bin_out", bus.bin_out, got.bin);
                check("err", bus.err, got.err);
            end
            prev_v   = bus.out_valid;
            prev_rdy = bus.out_ready;
            prev_bin = bus.bin_out;
            prev_err = bus.err;
        end
    end

    task automatic send(input logic [4*ND-1:0] b, input bit push);
        int t = 0;
        while (!bus.in_ready && t < 300) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check("in_ready_timeout", bus.in_ready, 1);
        bus.bcd_in   = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (push) exp_q.push_back(model(b, cyc));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && t < 500) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [4*ND-1:0] b;
        int t;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.bcd_in   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bin_out", bus.bin_out, 0);
        check("rst_err", bus.err, 0);

        bus.out_ready = 1'b1;
        send(20'h99999, 1'b1);
        send(20'h00000, 1'b1);
        send(20'h01023, 1'b1);
        drain();

        send(20'h00001, 1'b1);
        send(20'h65535, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        send(20'h00777, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("hold_reached_done", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.bcd_in   = 20'h00555;
            check("in_ready_in_done", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("held_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("consumed_valid", bus.out_valid, 0);
        check("idle_after_consume", bus.in_ready, 1);
        drain();

        send(20'h12345, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_in_ready", bus.in_ready, 1);
        repeat (25) @(posedge clk);
        #1 check("abort_no_result", bus.out_valid, 0);
        send(20'h00042, 1'b1);
        drain();

        send(20'h0A001, 1'b1);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < ND; k++) begin
                b[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            send(b, 1'b1);
        end
        drain();
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
